counter_bcd: RTL and testbench
==============================

# counter_bcd

Parametrised successor to the 8-bit counter plus combinational binary-to-BCD path. It holds an up/down counter with synchronous preload. A multi-cycle shift-and-add-3 (double-dabble) converter repeatedly snapshots the count and publishes a registered BCD value with update strobes. It sits between the counter stimulus (switches/buttons) and the 7-segment/display driver, replacing the wide combinational decoder with a small sequential one that scales with WIDTH.

## Interface
Parameters:
- WIDTH, 8, counter and preload width in bits (≥ 2)
- DIGITS, 3, number of BCD digits output; must satisfy 10^DIGITS > 2^WIDTH − 1

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset; synchronous, active-low (rst = 0 resets on the next rising clk edge)
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- ld  input  1  synchronous preload strobe
- v  input  WIDTH  preload value
- count  output  WIDTH  current counter value (registered)
- bcd  output  4*DIGITS  BCD of last converted snapshot, digit 0 in bits [3:0]
- bcd_valid  output  1  sticky: 1 once the first conversion after reset has completed
- bcd_upd  output  1  one-cycle pulse on the cycle bcd changes register value
- busy  output  1  1 while the converter is in CONV

## Operation
- Counter, per rising edge, priority order:
  - rst = 0: count ← 0.
  - ld = 1: count ← v. Load overrides en/up.
  - en = 1: count ← count ± 1 modulo 2^WIDTH. Wraps 2^WIDTH−1 → 0 (up) and 0 → 2^WIDTH−1 (down).
  - Otherwise: count holds.
- Converter FSM, states IDLE and CONV:
  - IDLE: on the edge, snap ← count, scratch ← 0, iter ← 0, go to CONV. IDLE therefore lasts exactly one cycle.
  - CONV: each edge performs one double-dabble step. Every scratch digit ≥ 5 gets +3, then {scratch, snap} shifts left by 1 and iter increments.
  - On the edge completing step WIDTH (iter = WIDTH−1): bcd ← final scratch, bcd_valid ← 1, go to IDLE.
  - bcd_upd is 1 for the cycle after a completion edge if the new bcd differs from the old bcd. Otherwise it is 0.
- Conversion is free-running and continuous. The snapshot is independent of en/ld. Count changes during CONV do not disturb the conversion in flight.
- Scratch is 4*DIGITS bits. Add-3 is applied per nibble and never carries across nibbles.

## Timing
- Reset values: count = 0, bcd = 0, bcd_valid = 0, bcd_upd = 0, busy = 0, FSM = IDLE, iter = 0.
- Reset mid-conversion aborts the conversion, discards the partial result, and applies all reset values. The first post-reset snapshot is taken on the first edge with rst = 1.
- Counter latency: 1 cycle from ld/en to count.
- Conversion period P = WIDTH + 1 cycles (1 IDLE + WIDTH CONV).
- busy is 0 only during the IDLE cycle.
- Snapshot taken at edge k appears on bcd at edge k + WIDTH. Worst-case latency from count change to bcd is 2·WIDTH + 1 cycles.
- With WIDTH = 8, the first bcd_valid rises 9 cycles after reset release.
- bcd is stable between completion edges and never shows partial results.
- Simultaneous ld and en: the load wins and no count step occurs that cycle.
- Simultaneous count change and snapshot edge: the snapshot takes the pre-edge count.

## Test plan
- Reset: hold rst = 0 for 3 cycles, then release with en = 0. Required: count = 0, bcd_valid = 0, busy = 0 during reset. bcd_valid = 1 and bcd = 12'h000 exactly 9 edges after release; bcd_upd stays 0.
- Preload max: ld = 1, v = 8'd255 for one cycle, en = 0. Required: count = 255 next cycle. bcd = 12'h255 within 17 cycles, with a single bcd_upd pulse.
- Up-count wrap: load 254, en = 1, up = 1 for 3 cycles. Required: count sequence 255, 0, 1, then hold at 1 with en = 0. Settled bcd = 12'h001.
- Down-count wrap: load 0, en = 1, up = 0 for 1 cycle. Required: count = 255. Settled bcd = 12'h255.
- Load priority: ld = 1, v = 8'd100, en = 1, up = 1 in the same cycle. Required: count = 100, not 101. Settled bcd = 12'h100.
- Mid-conversion reset: assert rst = 0 when busy = 1 and iter = 4, during conversion of 8'd199. Required: bcd = 0 and bcd_valid = 0 next cycle with no bcd_upd pulse. Also sweep all 256 loaded values and compare the settled bcd against a reference model.

Source files
------------

// File: rtl/counter_bcd.sv
// Up/down counter with synchronous preload, plus a free-running sequential
// binary-to-BCD converter (double-dabble, one bit per clock).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | one cycle; snapshot count, clear scratch, start conversion
// CONV  | WIDTH cycles; one add-3/shift step per edge, publish on last
module counter_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  ld,
    input  logic [WIDTH-1:0]      v,
    output logic [WIDTH-1:0]      count,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic                  bcd_upd,
    output logic                  busy
);

    localparam int SW = 4 * DIGITS;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] ITER_LAST = IW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   iter;
    logic [WIDTH-1:0] snap;
    logic [SW-1:0]   scratch;

    logic [SW-1:0]    scratch_adj;
    logic [SW-1:0]    scratch_nxt;
    logic [WIDTH-1:0] snap_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (ld) begin
            count <= v;
        end else if (en) begin
            count <= up ? count + 1'b1 : count - 1'b1;
        end
    end

    // Add-3 is per nibble; a digit never exceeds 9 here, so no cross-nibble carry.
    always_comb begin
        scratch_adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        {scratch_nxt, snap_nxt} = {scratch_adj, snap} << 1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            iter      <= '0;
            snap      <= '0;
            scratch   <= '0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
            bcd_upd   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bcd_upd <= 1'b0;
            case (state)
                IDLE: begin
                    snap    <= count;
                    scratch <= '0;
                    iter    <= '0;
                    state   <= CONV;
                    busy    <= 1'b1;
                end
                CONV: begin
                    scratch <= scratch_nxt;
                    snap    <= snap_nxt;
                    iter    <= iter + 1'b1;
                    if (iter == ITER_LAST) begin
                        bcd       <= scratch_nxt;
                        bcd_valid <= 1'b1;
                        bcd_upd   <= (scratch_nxt != bcd);
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_bcd.sv
// Directed bench for counter_bcd: stimulus pushes expected bcd values on a
// scoreboard queue, a monitor pops one per bcd_upd pulse.
module tb_counter_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        up;
    logic        ld;
    logic [7:0]  v;
    logic [7:0]  count;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic        bcd_upd;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    logic [11:0] model_bcd;

    counter_bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up        (up),
        .ld        (ld),
        .v         (v),
        .count     (count),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .bcd_upd   (bcd_upd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] bcd_ref(int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Bounded wait for the IDLE cycle; the following edge is a snapshot edge.
    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            cycle();
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still %b after %0d cycles", busy, n);
        end
    endtask

    // A settled count yields a pulse only if its BCD differs from the shown one.
    task automatic expect_settle(input int n);
        logic [11:0] e;
        e = bcd_ref(n);
        if (e != model_bcd) begin
            exp_q.push_back(e);
            model_bcd = e;
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && bcd_upd === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bcd_upd: unexpected pulse, bcd %0h expected none", bcd);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if (bcd !== e) begin
                    errors++;
                    $display("FAIL bcd_upd: bcd %0h expected %0h", bcd, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b1; ld = 1'b0; v = '0;
        model_bcd = 12'h000;

        repeat (3) begin
            cycle();
            chk("rst_count", count, 0);
            chk("rst_valid", bcd_valid, 0);
            chk("rst_busy", busy, 0);
        end

        rst = 1'b1;
        cycle();
        chk("first_busy", busy, 1);
        repeat (7) cycle();
        chk("valid_edge8", bcd_valid, 0);
        cycle();
        chk("valid_edge9", bcd_valid, 1);
        chk("bcd_edge9", bcd, 12'h000);
        chk("upd_edge9", bcd_upd, 0);
        chk("busy_idle", busy, 0);

        // preload max
        wait_idle();
        ld = 1'b1; v = 8'd255;
        cycle();
        ld = 1'b0;
        chk("load255", count, 255);
        expect_settle(255);

        // up-count wrap
        wait_idle();
        ld = 1'b1; v = 8'd254;
        cycle();
        ld = 1'b0;
        chk("load254", count, 254);
        en = 1'b1; up = 1'b1;
        cycle(); chk("up_255", count, 255);
        cycle(); chk("up_0", count, 0);
        cycle(); chk("up_1", count, 1);
        en = 1'b0;
        cycle(); chk("hold_1", count, 1);
        expect_settle(1);

        // down-count wrap
        wait_idle();
        ld = 1'b1; v = 8'd0;
        cycle();
        ld = 1'b0;
        chk("load0", count, 0);
        en = 1'b1; up = 1'b0;
        cycle();
        en = 1'b0;
        chk("down_255", count, 255);
        expect_settle(255);

        // load beats enable
        wait_idle();
        ld = 1'b1; v = 8'd100; en = 1'b1; up = 1'b1;
        cycle();
        ld = 1'b0; en = 1'b0;
        chk("ld_prio", count, 100);
        cycle();
        chk("ld_hold", count, 100);
        expect_settle(100);

        // reset while converting 199, at iter = 4
        wait_idle();
        ld = 1'b1; v = 8'd199;
        cycle();
        ld = 1'b0;
        wait_idle();
        cycle();
        chk("conv199_busy", busy, 1);
        repeat (4) cycle();
        chk("iter4_busy", busy, 1);
        chk("iter4_valid", bcd_valid, 1);
        rst = 1'b0;
        cycle();
        chk("midrst_bcd", bcd, 12'h000);
        chk("midrst_valid", bcd_valid, 0);
        chk("midrst_upd", bcd_upd, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_count", count, 0);
        model_bcd = 12'h000;
        chk("midrst_q_empty", exp_q.size(), 0);

        // sweep every loadable value
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wait_idle();
            ld = 1'b1; v = 8'(i);
            cycle();
            ld = 1'b0;
            chk("sweep_count", count, i);
            expect_settle(i);
        end
        repeat (20) cycle();
        chk("final_bcd", bcd, 12'h255);
        chk("final_valid", bcd_valid, 1);
        chk("q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
